// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: host command, SCL generator and pad signals of the I2C master.
// The master modport is the engine's view; the slave modport is the host/pad side.
interface i2c_master_ctrl_if;
    logic        start;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        gen_scl;
    logic        gen_half;
    logic        gen_en;
    logic        gen_run;
    logic        gen_idle;
    logic [15:0] gen_limit;
    logic        sda_in;
    logic        sda_oe;
    logic        scl_oe;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [7:0]  rdata;

    modport master (
        input  start, rw, addr, wdata, gen_scl, gen_half, gen_en, sda_in,
        output gen_run, gen_idle, gen_limit, sda_oe, scl_oe, busy, done, ack_err, rdata
    );

    modport slave (
        output start, rw, addr, wdata, gen_scl, gen_half, gen_en, sda_in,
        input  gen_run, gen_idle, gen_limit, sda_oe, scl_oe, busy, done, ack_err, rdata
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr+R/W, one data byte, STOP).
// Optional macro I2C_NACK_ABORT_EN: an address NACK skips the data phase and goes to STOP.
module i2c_master_ctrl #(
    parameter logic [15:0] CLK_DIV    = 16'd250,
    parameter logic [15:0] START_HOLD = 16'd125
) (
    input logic               clk,
    input logic               rst_n,
    i2c_master_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_ACK_A = 4'd3,
        ST_WRITE = 4'd4,
        ST_ACK_W = 4'd5,
        ST_READ  = 4'd6,
        ST_MNACK = 4'd7,
        ST_STOP  = 4'd8,
        ST_DONE  = 4'd9
    } state_e;

    state_e      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  wdata_q,     wdata_d;
    logic        rw_q,        rw_d;
    logic        half_prev_q, half_prev_d;
    logic        phase_q,     phase_d;
    logic        sda_oe_q,    sda_oe_d;
    logic        scl_oe_q,    scl_oe_d;
    logic        gen_run_q,   gen_run_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        ack_err_q,   ack_err_d;
    logic [7:0]  rdata_q,     rdata_d;

    logic mid_s;
    logic mid_lo_s;
    logic mid_hi_s;

    // phase_q marks that the current bit was launched on a low phase, so the
    // first SCL high phase after the generator starts is not taken as a sample.
    assign mid_s    = bus.gen_half & ~half_prev_q;
    assign mid_lo_s = mid_s & ~bus.gen_scl;
    assign mid_hi_s = mid_s & bus.gen_scl & phase_q;

    assign bus.gen_run   = gen_run_q;
    assign bus.gen_idle  = 1'b1;
    assign bus.gen_limit = CLK_DIV;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.rdata     = rdata_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            wdata_q     <= 8'd0;
            rw_q        <= 1'b0;
            half_prev_q <= 1'b0;
            phase_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            gen_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            rdata_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            half_prev_q <= half_prev_d;
            phase_q     <= phase_d;
            sda_oe_q    <= sda_oe_d;
            scl_oe_q    <= scl_oe_d;
            gen_run_q   <= gen_run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state and output logic of the protocol FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        gen_run_d   = gen_run_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_err_d   = ack_err_q;
        rdata_d     = rdata_q;
        half_prev_d = bus.gen_half;
        scl_oe_d    = bus.gen_en & ~bus.gen_scl;
        if (mid_lo_s) begin
            phase_d = 1'b1;
        end else if (mid_hi_s) begin
            phase_d = 1'b0;
        end else begin
            phase_d = phase_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (bus.start && !done_q) begin
                    shift_d   = {bus.addr, bus.rw};
                    wdata_d   = bus.wdata;
                    rw_d      = bus.rw;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    cnt_d     = 16'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_START;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                sda_oe_d = 1'b1;
                phase_d  = 1'b0;
                if (cnt_q == START_HOLD - 16'd1) begin
                    gen_run_d = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = ST_ADDR;
                end else begin
                    gen_run_d = 1'b0;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            ST_ADDR, ST_WRITE: begin
                if (mid_lo_s) begin
                    sda_oe_d = ~shift_q[7];
                end else if (mid_hi_s) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_W;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_ACK_A: begin
                if (mid_lo_s) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi_s) begin
                    ack_err_d = ack_err_q | bus.sda_in;
                    shift_d   = wdata_q;
`ifdef I2C_NACK_ABORT_EN
                    if (bus.sda_in) begin
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
`else
                    if (rw_q) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
`endif
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_ACK_W: begin
                if (mid_lo_s) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi_s) begin
                    ack_err_d = ack_err_q | bus.sda_in;
                    state_d   = ST_STOP;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_READ: begin
                sda_oe_d = 1'b0;
                if (mid_hi_s) begin
                    rdata_d   = {rdata_q[6:0], bus.sda_in};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_MNACK;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    rdata_d = rdata_q;
                end
            end
            ST_MNACK: begin
                sda_oe_d = 1'b0;
                if (mid_hi_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_MNACK;
                end
            end
            ST_STOP: begin
                // SDA is pulled low during SCL low, then released with SCL high.
                if (mid_lo_s) begin
                    sda_oe_d = 1'b1;
                end else if (mid_hi_s) begin
                    sda_oe_d  = 1'b0;
                    gen_run_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    sda_oe_d = sda_oe_q;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                gen_run_d = 1'b0;
                sda_oe_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: bench with SCL generator model, bus-level slave, and bit-sequence model.
// Directed vector table, hand sequences for corner cases, then randomized transactions.
module tb_i2c_master_ctrl;
    localparam logic [15:0] CD = 16'd10;
    localparam logic [15:0] SH = 16'd6;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_ctrl_if bus();
    i2c_master_ctrl #(.CLK_DIV(CD), .START_HOLD(SH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // SCL generator model: phase of gen_limit cycles, half_t high in second half.
    logic [15:0] g_cnt = 16'd0;
    logic        g_scl = 1'b1;
    logic        g_en  = 1'b0;
    always_ff @(posedge clk) begin
        if (!bus.gen_run) begin
            g_cnt <= 16'd0;
            g_scl <= bus.gen_idle;
            g_en  <= 1'b0;
        end else begin
            g_en <= 1'b1;
            if (g_cnt == bus.gen_limit - 16'd1) begin
                g_cnt <= 16'd0;
                g_scl <= ~g_scl;
            end else begin
                g_cnt <= g_cnt + 16'd1;
            end
        end
    end
    assign bus.gen_scl  = g_scl;
    assign bus.gen_en   = g_en;
    assign bus.gen_half = g_en && (g_cnt >= (bus.gen_limit >> 1));

    // Open-drain bus
    logic s_pull = 1'b0;
    logic sda, scl;
    assign sda = ~(bus.sda_oe | s_pull);
    assign scl = ~bus.scl_oe;
    assign bus.sda_in = sda;

    int checks = 0;
    int errors = 0;

    // Bus monitor / slave state
    int          starts = 0, stops = 0, illegal = 0, done_cnt = 0, obs_n = 0;
    logic [31:0] obs_v = 32'd0;
    logic        rw_seen = 1'b0;
    logic        s_ack = 1'b1;
    logic [7:0]  s_rd = 8'd0;
    logic [7:0]  prev_rdata = 8'd0;

    initial begin
        logic p_scl, p_sda, c_scl, c_sda;
        p_scl = 1'b1;
        p_sda = 1'b1;
        forever begin
            @(negedge clk);
            c_scl = scl;
            c_sda = sda;
            if (!rst_n) begin
                s_pull = 1'b0;
            end else begin
                if (p_scl && c_scl && p_sda && !c_sda) begin
                    starts++;
                    obs_n = 0;
                    obs_v = 32'd0;
                    s_pull = 1'b0;
                end else if (p_scl && c_scl && !p_sda && c_sda) begin
                    stops++;
                end else if ((p_sda != c_sda) && (p_scl || c_scl)) begin
                    illegal++;
                end
                if (!p_scl && c_scl) begin
                    obs_v = {obs_v[30:0], c_sda};
                    obs_n++;
                    if (obs_n == 8) rw_seen = c_sda;
                end
                if (p_scl && !c_scl) begin
                    if (obs_n == 8) s_pull = s_ack;
                    else if (rw_seen && s_ack && obs_n >= 9 && obs_n <= 16) s_pull = ~s_rd[16 - obs_n];
                    else if (!rw_seen && obs_n == 17) s_pull = s_ack;
                    else s_pull = 1'b0;
                end
                if (bus.done) done_cnt++;
            end
            p_scl = c_scl;
            p_sda = c_sda;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected SDA level at each SCL rising edge, straight from the protocol rules.
    function automatic void model_bits(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                                       input logic [7:0] rd, input logic ack,
                                       output logic [31:0] v, output int n);
        v = 32'd0;
        n = 0;
        for (int i = 6; i >= 0; i--) begin v = {v[30:0], a[i]}; n++; end
        v = {v[30:0], rw};   n++;
        v = {v[30:0], ~ack}; n++;
        if (!(ABORT && !ack)) begin
            for (int i = 7; i >= 0; i--) begin
                v = {v[30:0], rw ? (ack ? rd[i] : 1'b1) : wd[i]};
                n++;
            end
            v = {v[30:0], rw ? 1'b1 : ~ack};
            n++;
        end
        v = {v[30:0], 1'b0};
        n++;
    endfunction

    task automatic run_txn(input string nm, input logic rw, input logic [6:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input logic ack, input bit poke, input bit on_done);
        int          cyc, en;
        bit          got;
        logic [31:0] ev;
        logic [7:0]  er;
        s_rd = rd;
        s_ack = ack;
        starts = 0; stops = 0; illegal = 0; done_cnt = 0;
        @(posedge clk); #1;
        bus.rw = rw; bus.addr = a; bus.wdata = wd; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            if (poke && cyc == 200) begin
                bus.start = 1'b1; bus.rw = ~rw; bus.addr = ~a; bus.wdata = ~wd;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
        model_bits(rw, a, wd, rd, ack, ev, en);
        er = (rw && !(ABORT && !ack)) ? (ack ? rd : 8'hFF) : prev_rdata;
        prev_rdata = er;
        chk({nm, "_nbits"}, obs_n, en);
        chk({nm, "_bits"}, obs_v, ev);
        chk({nm, "_ack_err"}, {31'd0, bus.ack_err}, {31'd0, ~ack});
        chk({nm, "_rdata"}, {24'd0, bus.rdata}, {24'd0, er});
        chk({nm, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_start_stop"}, {starts[15:0], stops[15:0]}, 32'h0001_0001);
        chk({nm, "_bus_rule"}, illegal, 32'd0);
        chk({nm, "_latency"}, {31'd0, (cyc >= int'(SH) + (2 * en - 1) * int'(CD)) &&
                                      (cyc <= int'(SH) + (2 * en + 1) * int'(CD) + 6)}, 32'd1);
        if (on_done) begin
            bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'h11;
        end else begin
            bus.start = 1'b0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk({nm, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_one_done"}, done_cnt, 32'd1);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        logic       ack;
        logic       exp_ack_err;
        logic [7:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t vecs[4];
        vecs[0] = '{1'b0, 7'h50, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h1D, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 7'h7F, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h3C};
        vecs[3] = '{1'b1, 7'h2A, 8'h00, 8'hC3, 1'b1, 1'b0, 8'hC3};

        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'd0; bus.wdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe",  {31'd0, bus.sda_oe},  32'd0);
        chk("rst_scl_oe",  {31'd0, bus.scl_oe},  32'd0);
        chk("rst_gen_run", {31'd0, bus.gen_run}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_done",    {31'd0, bus.done},    32'd0);
        chk("rst_ack_err", {31'd0, bus.ack_err}, 32'd0);
        chk("rst_rdata",   {24'd0, bus.rdata},   32'd0);
        chk("gen_idle",    {31'd0, bus.gen_idle}, 32'd1);
        chk("gen_limit",   {16'd0, bus.gen_limit}, {16'd0, CD});
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rd, vecs[i].ack, 1'b0, 1'b0);
            chk($sformatf("vec%0d_tab_ack_err", i), {31'd0, bus.ack_err}, {31'd0, vecs[i].exp_ack_err});
            if (!(ABORT && !vecs[i].ack)) begin
                chk($sformatf("vec%0d_tab_rdata", i), {24'd0, bus.rdata}, {24'd0, vecs[i].exp_rdata});
            end
        end

        // start while busy must be ignored; start on the done cycle too
        run_txn("busy_start", 1'b0, 7'h33, 8'h11, 8'h00, 1'b1, 1'b1, 1'b0);
        run_txn("done_start", 1'b0, 7'h0C, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1);

        // asynchronous reset in the middle of the address phase
        @(posedge clk); #1;
        bus.rw = 1'b0; bus.addr = 7'h55; bus.wdata = 8'h00; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (int'(SH) + 5 * int'(CD)) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sda_oe",  {31'd0, bus.sda_oe},  32'd0);
        chk("mid_rst_scl_oe",  {31'd0, bus.scl_oe},  32'd0);
        chk("mid_rst_gen_run", {31'd0, bus.gen_run}, 32'd0);
        chk("mid_rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("mid_rst_rdata",   {24'd0, bus.rdata},   32'd0);
        prev_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 7'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
